instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Reader side of the 32 x 8-bit instruction ROM in the nibble CPU.
- Drives the ROM address from an internal program counter and reads the combinational ROM data in the same cycle.
- Assembles one- or two-byte instructions and hands each one to decode/execute over a valid/ready handshake.
- Handles control-flow redirects and halt requests from the execute stage.

Parameters:
- ADDR_W, 5: ROM address / PC width.
- DATA_W, 8: ROM word width; opcode = upper nibble, arg = lower nibble.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  ADDR_W  ROM address; equals the PC register.
- imem_data  in  DATA_W  ROM data; combinational from imem_addr.
- instr_valid  out  1  assembled instruction available.
- instr_ready  in  1  consumer accepts the instruction.
- instr_opcode  out  4  opcode byte bits [7:4].
- instr_arg  out  4  opcode byte bits [3:0].
- instr_imm  out  DATA_W  second byte; 0 for single-byte instructions.
- instr_two_byte  out  1  instruction carried an immediate byte.
- instr_pc  out  ADDR_W  address of the opcode byte.
- redir_valid  in  1  jump/branch taken.
- redir_addr  in  ADDR_W  redirect target.
- halt_req  in  1  stop fetching.
- halted  out  1  unit is in HALTED.

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC, state=FETCH_OP.
  - instr_valid=0, instr_opcode/arg/imm/pc=0, instr_two_byte=0, halted=0.
- States: FETCH_OP, FETCH_IMM, HOLD, HALTED.
- FETCH_OP:
  - Capture imem_data into opcode/arg; instr_pc<=PC; PC<=PC+1.
  - If is_two_byte(opcode): go to FETCH_IMM. Otherwise: imm<=0, go to HOLD.
  - Two-byte opcodes are 4'b0011 and 4'b0110; every other opcode is single-byte.
- FETCH_IMM: imm<=imem_data; PC<=PC+1; go to HOLD.
- HOLD:
  - instr_valid=1; all instr_* outputs are stable while valid && !ready.
  - On instr_ready: go to FETCH_OP, instr_valid<=0.
- Latency: valid rises 1 edge after FETCH_OP for single-byte instructions and 2 edges for two-byte. Steady throughput is one instruction per 2 or 3 cycles.
- PC arithmetic is modulo 2^ADDR_W: 31+1 wraps to 0. A two-byte opcode at address 31 takes its immediate from address 0.
- Redirect (highest priority in every state except HALTED):
  - PC<=redir_addr, state<=FETCH_OP, instr_valid<=0.
  - Any partially assembled or held instruction is discarded.
  - If redir_valid and instr_ready coincide in HOLD, the handshake counts as completed and the redirect also applies.
- Halt:
  - halt_req is sampled only in FETCH_OP with no redirect pending. The unit goes to HALTED, PC is frozen, and no ROM byte is consumed.
  - In HALTED: halted=1, instr_valid=0, halt_req is ignored.
  - Leave HALTED only via reset or redir_valid (goes to FETCH_OP at redir_addr, halted<=0).
- Reset mid-instruction: all state is discarded asynchronously; fetch restarts at RESET_PC.
- X on imem_data for the arg nibble is passed through unmodified. Opcode X is treated as single-byte.

Optional Feature:
- Macro INSTR_PREFETCH_EN.
- Defined: in HOLD, when instr_ready=1 and redir_valid=0, the byte at PC is captured as the next opcode in the same cycle, with PC<=PC+1. Next state is FETCH_IMM or HOLD per is_two_byte, and instr_valid stays 1. Single-byte instructions stream at 1 per cycle. A pending halt_req in that cycle blocks the prefetch and the unit goes to HALTED instead.
- Undefined: behaviour exactly as above; HOLD always returns to FETCH_OP.

Decomposition:
- Package nibble_cpu_pkg:
  - ADDR_W/DATA_W constants.
  - Opcode localparams (OP_LDI=4'b0011, OP_ALU_IMM=4'b0110).
  - fetch_state_t enum.
  - Function is_two_byte(opcode).
- One sub-module: fetch_pc_counter. ADDR_W-bit register with async reset to RESET_PC, load (redirect) and increment-with-wrap inputs; load has priority over increment.

Test Plan:
- ROM {0:0x22, 1:0x35, 2:0x07}, ready tied 1:
  - First instruction: opcode 2, arg 2, pc 0, two_byte 0.
  - Second instruction: opcode 3, arg 5, imm 0x07, pc 1, two_byte 1, valid 2 edges after its FETCH_OP.
- Backpressure: hold instr_ready=0 for 5 cycles in HOLD -> outputs stable, imem_addr unchanged. Ready=1 -> exactly one transfer.
- Wrap: redirect to 31 with ROM[31]=0x60, ROM[0]=0xAB -> imm 0xAB, pc 31, next fetch at address 1.
- Redirect during FETCH_IMM with redir_addr=0x10 -> partial instruction dropped, next valid instruction has pc 0x10.
- halt_req in FETCH_OP -> halted=1 next edge, imem_addr frozen. redir_valid with addr 4 -> resumes at 4, halted=0.
- With INSTR_PREFETCH_EN, four consecutive 0x22 words and ready=1 -> valid stays high, one handshake per cycle, pc 0,1,2,3.

Source files
------------

// File: rtl/nibble_cpu_pkg.sv
// Shared constants, opcode encodings, fetch FSM states and the instruction-length decode
// for the nibble CPU.
package nibble_cpu_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  localparam logic [3:0] OP_LDI     = 4'b0011;
  localparam logic [3:0] OP_ALU_IMM = 4'b0110;

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_IMM = 2'd1,
    HOLD      = 2'd2,
    HALTED    = 2'd3
  } fetch_state_t;

  // Unknown opcodes fall to the default arm, so they decode as single-byte
  function automatic logic is_two_byte(input logic [3:0] opcode);
    logic two_s;
    case (opcode)
      OP_LDI, OP_ALU_IMM: two_s = 1'b1;
      default:            two_s = 1'b0;
    endcase
    return two_s;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction hand-off channel between the fetch unit (master) and decode/execute (slave).
interface instruction_fetch_unit_if;
  import nibble_cpu_pkg::*;

  logic              instr_valid;
  logic              instr_ready;
  logic [3:0]        instr_opcode;
  logic [3:0]        instr_arg;
  logic [DATA_W-1:0] instr_imm;
  logic              instr_two_byte;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output instr_valid, instr_opcode, instr_arg, instr_imm, instr_two_byte, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_opcode, instr_arg, instr_imm, instr_two_byte, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/fetch_pc_counter.sv
// Program counter: async reset to RESET_PC, redirect load beats increment, wraps modulo 2^ADDR_W.
module fetch_pc_counter #(
  parameter int                ADDR_W   = 5,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_r;

  // PC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else if (load) begin
      pc_r <= load_addr;
    end else if (inc) begin
      pc_r <= pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetches one- or two-byte instructions from the instruction ROM and hands them to decode.
// Optional macro INSTR_PREFETCH_EN lets HOLD capture the next opcode during a handshake.
module instruction_fetch_unit #(
  parameter int                ADDR_W   = nibble_cpu_pkg::ADDR_W,
  parameter int                DATA_W   = nibble_cpu_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [DATA_W-1:0]        imem_data,
  instruction_fetch_unit_if.master instr,
  input  logic                     redir_valid,
  input  logic [ADDR_W-1:0]        redir_addr,
  input  logic                     halt_req,
  output logic                     halted
);
  import nibble_cpu_pkg::*;

  fetch_state_t      state_r, state_nx_s;
  logic [ADDR_W-1:0] pc_s;
  logic              pc_load_s, pc_inc_s, cap_op_s, cap_imm_s;
  logic              valid_r, valid_nx_s, halted_r, halted_nx_s;
  logic [3:0]        opcode_r, arg_r;
  logic [DATA_W-1:0] imm_r;
  logic              two_byte_r;
  logic [ADDR_W-1:0] instr_pc_r;
  logic [3:0]        op_s, arg_s;
  logic              two_s;

  assign op_s  = imem_data[DATA_W-1:DATA_W-4];
  assign arg_s = imem_data[3:0];
  assign two_s = is_two_byte(op_s);

  fetch_pc_counter #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (pc_load_s),
    .load_addr (redir_addr),
    .inc       (pc_inc_s),
    .pc        (pc_s)
  );

  // Next-state and datapath enables; a redirect outranks everything outside HALTED
  always_comb begin
    state_nx_s  = state_r;
    pc_load_s   = 1'b0;
    pc_inc_s    = 1'b0;
    cap_op_s    = 1'b0;
    cap_imm_s   = 1'b0;
    valid_nx_s  = valid_r;
    halted_nx_s = halted_r;
    if (redir_valid) begin
      pc_load_s   = 1'b1;
      state_nx_s  = FETCH_OP;
      valid_nx_s  = 1'b0;
      halted_nx_s = 1'b0;
    end else begin
      case (state_r)
        FETCH_OP: begin
          if (halt_req) begin
            state_nx_s  = HALTED;
            halted_nx_s = 1'b1;
            valid_nx_s  = 1'b0;
          end else begin
            cap_op_s   = 1'b1;
            pc_inc_s   = 1'b1;
            state_nx_s = two_s ? FETCH_IMM : HOLD;
            valid_nx_s = !two_s;
          end
        end
        FETCH_IMM: begin
          cap_imm_s  = 1'b1;
          pc_inc_s   = 1'b1;
          state_nx_s = HOLD;
          valid_nx_s = 1'b1;
        end
        HOLD: begin
          if (instr.instr_ready) begin
`ifdef INSTR_PREFETCH_EN
            if (halt_req) begin
              state_nx_s  = HALTED;
              halted_nx_s = 1'b1;
              valid_nx_s  = 1'b0;
            end else begin
              // A prefetched two-byte opcode is not offered until its immediate arrives
              cap_op_s   = 1'b1;
              pc_inc_s   = 1'b1;
              state_nx_s = two_s ? FETCH_IMM : HOLD;
              valid_nx_s = !two_s;
            end
`else
            state_nx_s = FETCH_OP;
            valid_nx_s = 1'b0;
`endif
          end else begin
            state_nx_s = HOLD;
          end
        end
        HALTED: begin
          state_nx_s = HALTED;
        end
        default: begin
          state_nx_s  = FETCH_OP;
          valid_nx_s  = 1'b0;
          halted_nx_s = 1'b0;
        end
      endcase
    end
  end

  // State and registered instruction outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= FETCH_OP;
      valid_r    <= 1'b0;
      halted_r   <= 1'b0;
      opcode_r   <= 4'h0;
      arg_r      <= 4'h0;
      imm_r      <= {DATA_W{1'b0}};
      two_byte_r <= 1'b0;
      instr_pc_r <= {ADDR_W{1'b0}};
    end else begin
      state_r  <= state_nx_s;
      valid_r  <= valid_nx_s;
      halted_r <= halted_nx_s;
      if (cap_op_s) begin
        opcode_r   <= op_s;
        arg_r      <= arg_s;
        two_byte_r <= two_s;
        instr_pc_r <= pc_s;
        imm_r      <= {DATA_W{1'b0}};
      end else if (cap_imm_s) begin
        imm_r <= imem_data;
      end else begin
        imm_r <= imm_r;
      end
    end
  end

  assign imem_addr            = pc_s;
  assign halted               = halted_r;
  assign instr.instr_valid    = valid_r;
  assign instr.instr_opcode   = opcode_r;
  assign instr.instr_arg      = arg_r;
  assign instr.instr_imm      = imm_r;
  assign instr.instr_two_byte = two_byte_r;
  assign instr.instr_pc       = instr_pc_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed and randomized bench for instruction_fetch_unit against a ROM-walk reference model.
module tb_instruction_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] imem_addr;
  logic [7:0] imem_data;
  logic       redir_valid;
  logic [4:0] redir_addr;
  logic       halt_req;
  logic       halted;
  logic [7:0] rom [32];
  int         errors = 0;
  int         checks = 0;

  instruction_fetch_unit_if ifc ();

  instruction_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .instr       (ifc),
    .redir_valid (redir_valid),
    .redir_addr  (redir_addr),
    .halt_req    (halt_req),
    .halted      (halted)
  );

  assign imem_data = rom[imem_addr];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [21:0] fields();
    return {ifc.instr_opcode, ifc.instr_arg, ifc.instr_imm, ifc.instr_two_byte, ifc.instr_pc};
  endfunction

  function automatic bit model_two(input logic [7:0] b);
    return ((b >> 4) == 8'd3) || ((b >> 4) == 8'd6);
  endfunction

  initial begin
    logic [21:0] snap;
    int          exp_pc;
    int          xfers;
    bit          prev_hold;
    bit          rdy, rd;
    logic [4:0]  ra;
    logic [7:0]  ob;

    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    rom[0] = 8'h22; rom[1] = 8'h35; rom[2] = 8'h07;
    rst_n = 1'b0; ifc.instr_ready = 1'b1;
    redir_valid = 1'b0; redir_addr = 5'd0; halt_req = 1'b0;
    #2;
    chk("rst_valid", ifc.instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fields", fields(), 0);
    chk("rst_addr", imem_addr, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // single-byte then two-byte instruction
    step();
    chk("i0_valid", ifc.instr_valid, 1);
    chk("i0_fields", fields(), {4'h2, 4'h2, 8'h00, 1'b0, 5'd0});
    step();
    chk("i0_done", ifc.instr_valid, 0);
    step();
    chk("i1_fetch_imm_valid", ifc.instr_valid, 0);
    step();
    chk("i1_valid", ifc.instr_valid, 1);
    chk("i1_fields", fields(), {4'h3, 4'h5, 8'h07, 1'b1, 5'd1});

    // backpressure
    ifc.instr_ready = 1'b0;
    snap = fields();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_valid", ifc.instr_valid, 1);
      chk("bp_fields", fields(), snap);
      chk("bp_addr", imem_addr, 3);
    end
    ifc.instr_ready = 1'b1;
    step();
    chk("bp_release", ifc.instr_valid, 0);
    ifc.instr_ready = 1'b0;
    step();
    chk("bp_next", {ifc.instr_valid, ifc.instr_pc}, {1'b1, 5'd3});

    // wrap at address 31
    rom[31] = 8'h60; rom[0] = 8'hAB;
    redir_valid = 1'b1; redir_addr = 5'd31;
    step();
    redir_valid = 1'b0;
    chk("wrap_redir_addr", imem_addr, 31);
    chk("wrap_redir_valid", ifc.instr_valid, 0);
    step();
    step();
    chk("wrap_valid", ifc.instr_valid, 1);
    chk("wrap_fields", fields(), {4'h6, 4'h0, 8'hAB, 1'b1, 5'd31});
    chk("wrap_addr", imem_addr, 1);

    // redirect during FETCH_IMM
    rom[5] = 8'h3F; rom[6] = 8'h11; rom[16] = 8'h41;
    redir_valid = 1'b1; redir_addr = 5'd5;
    step();
    redir_valid = 1'b0;
    step();
    chk("rfi_mid_valid", ifc.instr_valid, 0);
    redir_valid = 1'b1; redir_addr = 5'h10;
    step();
    redir_valid = 1'b0;
    chk("rfi_addr", imem_addr, 16);
    chk("rfi_drop", ifc.instr_valid, 0);
    step();
    chk("rfi_valid", ifc.instr_valid, 1);
    chk("rfi_fields", fields(), {4'h4, 4'h1, 8'h00, 1'b0, 5'd16});

    // halt and resume
    ifc.instr_ready = 1'b1;
    step();
    chk("halt_pre_addr", imem_addr, 17);
    halt_req = 1'b1;
    step();
    chk("halt_halted", halted, 1);
    chk("halt_valid", ifc.instr_valid, 0);
    chk("halt_addr", imem_addr, 17);
    step(); step();
    chk("halt_frozen", {halted, imem_addr}, {1'b1, 5'd17});
    halt_req = 1'b0;
    rom[4] = 8'h9C;
    redir_valid = 1'b1; redir_addr = 5'd4;
    step();
    redir_valid = 1'b0;
    chk("resume_halted", halted, 0);
    chk("resume_addr", imem_addr, 4);
    step();
    chk("resume_instr", {ifc.instr_valid, fields()}, {1'b1, 4'h9, 4'hC, 8'h00, 1'b0, 5'd4});

`ifdef INSTR_PREFETCH_EN
    for (int i = 0; i < 4; i++) rom[i] = 8'h22;
    rom[4] = 8'h00;
    redir_valid = 1'b1; redir_addr = 5'd0;
    step();
    redir_valid = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("pf_valid", ifc.instr_valid, 1);
      chk("pf_pc", ifc.instr_pc, i);
      step();
    end
`endif

    // randomized run against a ROM-walk model
    for (int i = 0; i < 32; i++) rom[i] = 8'($urandom);
    redir_valid = 1'b1; redir_addr = 5'd0;
    step();
    redir_valid = 1'b0;
    exp_pc = 0; xfers = 0; prev_hold = 1'b0; snap = '0;
    for (int c = 0; c < 500; c++) begin
      rdy = ($urandom_range(0, 9) < 7);
      rd  = ($urandom_range(0, 19) == 0);
      ra  = 5'($urandom_range(0, 31));
      if (prev_hold) begin
        chk("rnd_stall_valid", ifc.instr_valid, 1);
        chk("rnd_stall_fields", fields(), snap);
      end
      ifc.instr_ready = rdy; redir_valid = rd; redir_addr = ra;
      if (ifc.instr_valid && rdy) begin
        ob = rom[exp_pc];
        chk("rnd_pc", ifc.instr_pc, exp_pc);
        chk("rnd_opcode", ifc.instr_opcode, ob >> 4);
        chk("rnd_arg", ifc.instr_arg, ob % 16);
        chk("rnd_two", ifc.instr_two_byte, model_two(ob));
        chk("rnd_imm", ifc.instr_imm, model_two(ob) ? rom[(exp_pc + 1) % 32] : 8'h00);
        exp_pc = (exp_pc + (model_two(ob) ? 2 : 1)) % 32;
        xfers++;
      end
      if (rd) exp_pc = ra;
      prev_hold = ifc.instr_valid && !rdy && !rd;
      snap = fields();
      step();
    end
    redir_valid = 1'b0;
    chk("rnd_progress", (xfers > 50) ? 1 : 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
